// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared RV32M op codes, muldiv state encoding and XLEN
package riscv_core_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] MULDIV_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_REM    = 3'd6;
  localparam logic [2:0] MULDIV_REMU   = 3'd7;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;
endpackage

// File: rtl/riscv_core_muldiv_negate.sv
// riscv_core_muldiv_negate: conditional two's-complement of a WIDTH-bit value
module riscv_core_muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = en ? -a : a;
endmodule

// File: rtl/riscv_core_muldiv_unit.sv
// riscv_core_muldiv_unit: iterative RV32M multiply/divide with busy/valid handshake
module riscv_core_muldiv_unit
  import riscv_core_pkg::*;
#(
  parameter int XLEN = riscv_core_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_muldiv_start,
  input  logic [2:0]      i_muldiv_op,
  input  logic [XLEN-1:0] i_muldiv_rs1,
  input  logic [XLEN-1:0] i_muldiv_rs2,
  input  logic            i_muldiv_flush,
  output logic            o_muldiv_busy,
  output logic            o_muldiv_valid,
  output logic [XLEN-1:0] o_muldiv_result
);
  localparam int CW = $clog2(XLEN);
  muldiv_state_t state, state_n;
  logic [2:0] op;
  logic s1, s2;
  logic [XLEN-1:0] a, b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0] rem;
  logic [CW-1:0] cnt;
  logic sgn1, sgn2, div_zero, ovf, special, accept;
  logic [XLEN-1:0] abs1, abs2, spec_res, q_fix, r_fix, fix_res;
  logic [2*XLEN-1:0] prod_fix, mul_next, div_next;
  logic [XLEN:0] mul_sum, rem_sh, diff;
  assign sgn1 = i_muldiv_rs1[XLEN-1] & (i_muldiv_op == MULDIV_MULH | i_muldiv_op == MULDIV_MULHSU |
                                        (i_muldiv_op[2] & ~i_muldiv_op[0]));
  assign sgn2 = i_muldiv_rs2[XLEN-1] & (i_muldiv_op == MULDIV_MULH | (i_muldiv_op[2] & ~i_muldiv_op[0]));
  assign div_zero = i_muldiv_op[2] & (i_muldiv_rs2 == '0);
  assign ovf = i_muldiv_op[2] & ~i_muldiv_op[0] & (i_muldiv_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &
               (i_muldiv_rs2 == '1);
  assign special = div_zero | ovf;
  assign spec_res = div_zero ? (i_muldiv_op[1] ? i_muldiv_rs1 : '1)
                             : (i_muldiv_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  assign accept = i_muldiv_start & ~i_muldiv_flush & (state == IDLE);
  riscv_core_muldiv_negate #(.WIDTH(XLEN)) u_abs1 (.en(sgn1), .a(i_muldiv_rs1), .y(abs1));
  riscv_core_muldiv_negate #(.WIDTH(XLEN)) u_abs2 (.en(sgn2), .a(i_muldiv_rs2), .y(abs2));
  riscv_core_muldiv_negate #(.WIDTH(2*XLEN)) u_prod (.en(s1 ^ s2), .a(acc), .y(prod_fix));
  riscv_core_muldiv_negate #(.WIDTH(XLEN)) u_quot (.en(s1 ^ s2), .a(acc[XLEN-1:0]), .y(q_fix));
  riscv_core_muldiv_negate #(.WIDTH(XLEN)) u_rem (.en(s1), .a(rem[XLEN-1:0]), .y(r_fix));
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, acc[0] ? a : '0};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign rem_sh = {rem[XLEN-1:0], acc[XLEN-1]};
  assign diff = rem_sh - {1'b0, b};
  assign div_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~diff[XLEN]};
  assign fix_res = op[2] ? (op[1] ? r_fix : q_fix)
                         : (op == MULDIV_MUL ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = i_muldiv_start ? (special ? DONE : CALC) : IDLE;
      CALC: state_n = (cnt == CW'(XLEN-1)) ? FIX : CALC;
      FIX:  state_n = DONE;
      DONE: state_n = IDLE;
    endcase
    if (i_muldiv_flush) state_n = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      a <= '0;
      b <= '0;
      acc <= '0;
      rem <= '0;
      cnt <= '0;
      o_muldiv_result <= '0;
    end else begin
      if (accept) begin
        op <= i_muldiv_op;
        s1 <= sgn1;
        s2 <= sgn2;
        a <= abs1;
        b <= abs2;
        acc <= {{XLEN{1'b0}}, i_muldiv_op[2] ? abs1 : abs2};
        rem <= '0;
        cnt <= '0;
        if (special) o_muldiv_result <= spec_res;
      end
      if (state == CALC) begin
        acc <= op[2] ? div_next : mul_next;
        rem <= (op[2] & ~diff[XLEN]) ? diff : (op[2] ? rem_sh : rem);
        cnt <= cnt + 1'b1;
      end
      if (state == FIX && !i_muldiv_flush) o_muldiv_result <= fix_res;
    end
  end
  assign o_muldiv_busy = state != IDLE;
  assign o_muldiv_valid = state == DONE;
endmodule

// File: doc/riscv_core_muldiv_unit.md
Name: riscv_core_muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide unit in the execute stage, downstream of the ALU decoder.
- Consumes the 3-bit M-extension operation code the decoder emits when funct7[0]=1 and opcode[5]=1 (alucontrol values 0-7).
- Computes the result over several cycles.
- Tells the pipeline controller, via a busy/valid handshake, when to stall and when the result is ready to write back.

Parameters:
XLEN, 32, operand and result width in bits.

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_rst  input  1  synchronous, active-high reset
i_muldiv_start  input  1  request; accepted only when the unit is in IDLE
i_muldiv_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_muldiv_rs1  input  XLEN  operand A (multiplicand / dividend)
i_muldiv_rs2  input  XLEN  operand B (multiplier / divisor)
i_muldiv_flush  input  1  abort any operation in progress
o_muldiv_busy  output  1  high whenever state != IDLE
o_muldiv_valid  output  1  one-cycle pulse; o_muldiv_result is valid in that cycle
o_muldiv_result  output  XLEN  result; holds its value until the next valid pulse

Behaviour:
Reset:
- i_rst=1 at any edge, including mid-operation, forces state to IDLE.
- Reset values: o_muldiv_busy=0, o_muldiv_valid=0, o_muldiv_result=0. All internal registers are cleared.
- No valid pulse is produced for an operation killed by reset.

States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Start high at edge T: latch op, operand signs and absolute values.
    - Signed operands: MULH rs1/rs2, MULHSU rs1 only, DIV/REM both.
    - Unsigned ops use raw values.
  - Special case detected at accept goes IDLE->DONE with the result preloaded, so valid is high in cycle T+1:
    - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
  - Otherwise the next state is CALC with the iteration counter at 0.
- CALC: exactly XLEN cycles, counter 0..XLEN-1.
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - Divide: restoring radix-2, one quotient bit per cycle; partial remainder is XLEN+1 bits.
  - After the counter reaches XLEN-1, go to FIX.
- FIX: one cycle.
  - Negate the 2*XLEN product if the result sign is 1 (rs1 sign XOR rs2 sign, over the signed operands only).
  - Negate the quotient if the dividend sign XOR divisor sign is 1.
  - Negate the remainder if the dividend sign is 1.
  - Select the result:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register o_muldiv_result; go to DONE.
- DONE: o_muldiv_valid=1 for exactly one cycle, then IDLE.

Latency:
- Normal op accepted at edge T: valid in cycle T+XLEN+2 (T+34 at XLEN=32).
- Special case: valid in cycle T+1.
- Throughput: a new start is accepted no earlier than the cycle after DONE.

Handshake and boundaries:
- Start while busy (CALC/FIX/DONE) is ignored; no queuing.
- Start and flush in the same cycle in IDLE: flush wins, no accept.
- Flush in CALC/FIX/DONE forces IDLE next edge, no valid pulse, o_muldiv_result unchanged.
- Reset has priority over flush and start.
- Operand inputs are sampled only at accept and may change freely afterwards.
- Op codes are 3 bits, so every code is legal.

Decomposition:
- Shared package riscv_core_pkg holds:
  - the MULDIV_* op localparams (0-7),
  - the state encoding (IDLE=0, CALC=1, FIX=2, DONE=3),
  - XLEN.
- One natural sub-module, riscv_core_muldiv_negate: conditional two's-complement of a WIDTH-bit value. It is instantiated for operand abs-value at accept and for product/quotient/remainder sign fix.
- The FSM and datapath stay in one module.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at T -> busy T+1..T+34, valid only in T+34, result 0xFFFFFFEB; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> valid at T+1, result 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM same operands -> 0.
- Start a DIV, pulse start again at T+5 with different operands -> ignored, first result returned at T+34; flush at T+10 -> busy=0 at T+11, no valid pulse, result unchanged.
- Assert i_rst at T+20 of a MUL -> next cycle busy=0, valid=0, result=0; a new start afterwards completes normally.
